// File: rtl/err_collect.sv
// err_collect: buffers one candidate error vector's indices and serves them through a pop port
module err_collect #(
    parameter int IDX_W = 13,
    parameter int DEPTH = 64,
    parameter int N_MAX = 4900
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [1:0]       err_valid,
    input  logic [IDX_W-1:0] err_idx,
    input  logic             rd_en,
    output logic             vec_ready,
    output logic [6:0]       weight,
    output logic [IDX_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_empty,
    output logic             err_range,
    output logic             err_ovf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, READY} state_t;

    state_t           state;
    logic [IDX_W-1:0] mem [DEPTH];
    logic [6:0]       wr_cnt;
    logic [6:0]       rd_ptr;
    logic [1:0]       prev_code;
    logic             code_idx;
    logic             code_clr;
    logic             done_evt;
    logic             wr_ok;
    logic             pop;

    // Stream decode; a done is only the rising transition into 11, since the generator parks on 11
    always_comb begin
        code_idx  = err_valid == 2'b01;
        code_clr  = err_valid == 2'b10;
        done_evt  = err_valid == 2'b11 && prev_code != 2'b11;
        wr_ok     = state == COLLECT && code_idx && wr_cnt != 7'(DEPTH);
        pop       = state == READY && !code_clr && rd_en && rd_ptr < weight;
        vec_ready = state == READY;
        rd_empty  = state != READY || rd_ptr == weight;
    end

    // Index storage; contents are don't-care after reset so no reset term is needed
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_cnt[AW-1:0]] <= err_idx;
    end

    // Collect / ready / drain control with registered read port and sticky flags
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            prev_code <= 2'b11;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            weight    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            err_range <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            prev_code <= err_valid;
            rd_valid  <= 1'b0;
            if (pop) begin
                rd_data  <= mem[rd_ptr[AW-1:0]];
                rd_valid <= 1'b1;
                rd_ptr   <= rd_ptr + 7'd1;
            end
            case (state)
                IDLE: begin
                    if (code_clr) begin
                        state     <= COLLECT;
                        wr_cnt    <= '0;
                        err_range <= 1'b0;
                        err_ovf   <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (code_clr) begin
                        wr_cnt    <= '0;
                        err_range <= 1'b0;
                        err_ovf   <= 1'b0;
                    end else if (code_idx) begin
                        if (err_idx >= IDX_W'(N_MAX)) err_range <= 1'b1;
                        if (wr_cnt == 7'(DEPTH)) err_ovf <= 1'b1;
                        else wr_cnt <= wr_cnt + 7'd1;
                    end else if (done_evt) begin
                        weight <= wr_cnt;
                        rd_ptr <= '0;
                        state  <= READY;
                    end
                end
                READY: begin
                    if (code_clr) begin
                        state     <= COLLECT;
                        wr_cnt    <= '0;
                        err_range <= 1'b0;
                        err_ovf   <= 1'b0;
                    end else if (rd_ptr == weight) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_err_collect.sv
// tb_err_collect: directed scenario bench for err_collect
module tb_err_collect;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [1:0]  err_valid = 2'b11;
    logic [12:0] err_idx = '0;
    logic        rd_en = 1'b0;
    logic        vec_ready;
    logic [6:0]  weight;
    logic [12:0] rd_data;
    logic        rd_valid;
    logic        rd_empty;
    logic        err_range;
    logic        err_ovf;
    logic [10:0] st;
    int          passed = 0;
    int          total = 0;

    err_collect dut (
        .clk(clk), .rst_b(rst_b), .err_valid(err_valid), .err_idx(err_idx), .rd_en(rd_en),
        .vec_ready(vec_ready), .weight(weight), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_empty(rd_empty), .err_range(err_range), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // status word: vec_ready, weight, rd_empty, err_range, err_ovf
    assign st = {vec_ready, weight, rd_empty, err_range, err_ovf};

    task automatic cyc(input logic [1:0] v, input logic [12:0] idx, input logic rd);
        err_valid = v;
        err_idx   = idx;
        rd_en     = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        total++; if ({st, rd_valid, rd_data} !== {1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0})
            $display("FAIL reset_in got %h exp %h", {st, rd_valid, rd_data}, {1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0});
        else passed++;
        rst_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(2'b11, 13'd0, 1'b0);
            total++; if (vec_ready !== 1'b0) $display("FAIL reset_hold11 cyc %0d got %b exp 0", i, vec_ready);
            else passed++;
        end
        total++; if ({st, rd_valid, rd_data} !== {1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0})
            $display("FAIL reset_after got %h exp %h", {st, rd_valid, rd_data}, {1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0});
        else passed++;
    endtask

    task automatic test_basic;
        logic [12:0] exp_d [3];
        exp_d[0] = 13'd17; exp_d[1] = 13'd4898; exp_d[2] = 13'd3;
        cyc(2'b10, 13'd0, 1'b0);
        cyc(2'b01, 13'd17, 1'b0);
        cyc(2'b01, 13'd4898, 1'b0);
        cyc(2'b00, 13'd0, 1'b0);
        cyc(2'b01, 13'd3, 1'b0);
        total++; if (vec_ready !== 1'b0) $display("FAIL basic_pre_done got %b exp 0", vec_ready);
        else passed++;
        cyc(2'b11, 13'd0, 1'b0);
        total++; if (st !== {1'b1, 7'd3, 1'b0, 1'b0, 1'b0}) $display("FAIL basic_done got %h exp %h", st, {1'b1, 7'd3, 1'b0, 1'b0, 1'b0});
        else passed++;
        for (int i = 0; i < 3; i++) begin
            cyc(2'b11, 13'd0, 1'b1);
            total++; if ({rd_valid, rd_data} !== {1'b1, exp_d[i]}) $display("FAIL basic_pop%0d got %h exp %h", i, {rd_valid, rd_data}, {1'b1, exp_d[i]});
            else passed++;
        end
        total++; if (st !== {1'b1, 7'd3, 1'b1, 1'b0, 1'b0}) $display("FAIL basic_drained got %h exp %h", st, {1'b1, 7'd3, 1'b1, 1'b0, 1'b0});
        else passed++;
        cyc(2'b11, 13'd0, 1'b1);
        total++; if ({vec_ready, rd_empty, rd_valid} !== 3'b010) $display("FAIL basic_idle got %b exp 010", {vec_ready, rd_empty, rd_valid});
        else passed++;
    endtask

    task automatic test_retry;
        cyc(2'b10, 13'd0, 1'b0);
        cyc(2'b01, 13'd5, 1'b0);
        cyc(2'b01, 13'd6, 1'b0);
        cyc(2'b10, 13'd0, 1'b0);
        cyc(2'b01, 13'd9, 1'b0);
        cyc(2'b11, 13'd0, 1'b0);
        total++; if (st !== {1'b1, 7'd1, 1'b0, 1'b0, 1'b0}) $display("FAIL retry_done got %h exp %h", st, {1'b1, 7'd1, 1'b0, 1'b0, 1'b0});
        else passed++;
        cyc(2'b11, 13'd0, 1'b1);
        total++; if ({rd_valid, rd_data} !== {1'b1, 13'd9}) $display("FAIL retry_pop got %h exp %h", {rd_valid, rd_data}, {1'b1, 13'd9});
        else passed++;
        cyc(2'b00, 13'd0, 1'b0);
        total++; if ({vec_ready, rd_valid} !== 2'b00) $display("FAIL retry_idle got %b exp 00", {vec_ready, rd_valid});
        else passed++;
    endtask

    task automatic test_ovf;
        cyc(2'b10, 13'd0, 1'b0);
        for (int i = 0; i < 66; i++) cyc(2'b01, 13'(i), 1'b0);
        cyc(2'b11, 13'd0, 1'b0);
        total++; if (st !== {1'b1, 7'd64, 1'b0, 1'b0, 1'b1}) $display("FAIL ovf_done got %h exp %h", st, {1'b1, 7'd64, 1'b0, 1'b0, 1'b1});
        else passed++;
        for (int i = 0; i < 64; i++) begin
            cyc(2'b11, 13'd0, 1'b1);
            total++; if ({rd_valid, rd_data} !== {1'b1, 13'(i)}) $display("FAIL ovf_pop%0d got %h exp %h", i, {rd_valid, rd_data}, {1'b1, 13'(i)});
            else passed++;
        end
        total++; if (st !== {1'b1, 7'd64, 1'b1, 1'b0, 1'b1}) $display("FAIL ovf_drained got %h exp %h", st, {1'b1, 7'd64, 1'b1, 1'b0, 1'b1});
        else passed++;
        cyc(2'b00, 13'd0, 1'b0);
        total++; if (vec_ready !== 1'b0) $display("FAIL ovf_idle got %b exp 0", vec_ready);
        else passed++;
    endtask

    task automatic test_range;
        cyc(2'b10, 13'd0, 1'b0);
        total++; if ({err_range, err_ovf} !== 2'b00) $display("FAIL range_clr got %b exp 00", {err_range, err_ovf});
        else passed++;
        cyc(2'b01, 13'd4900, 1'b0);
        cyc(2'b01, 13'd8191, 1'b0);
        cyc(2'b11, 13'd0, 1'b0);
        total++; if (st !== {1'b1, 7'd2, 1'b0, 1'b1, 1'b0}) $display("FAIL range_done got %h exp %h", st, {1'b1, 7'd2, 1'b0, 1'b1, 1'b0});
        else passed++;
        cyc(2'b01, 13'd100, 1'b0);
        total++; if (st !== {1'b1, 7'd2, 1'b0, 1'b1, 1'b0}) $display("FAIL range_idx_in_ready got %h exp %h", st, {1'b1, 7'd2, 1'b0, 1'b1, 1'b0});
        else passed++;
        cyc(2'b00, 13'd0, 1'b1);
        total++; if ({rd_valid, rd_data} !== {1'b1, 13'd4900}) $display("FAIL range_pop0 got %h exp %h", {rd_valid, rd_data}, {1'b1, 13'd4900});
        else passed++;
        cyc(2'b00, 13'd0, 1'b0);
        total++; if (rd_valid !== 1'b0) $display("FAIL range_valid_pulse got %b exp 0", rd_valid);
        else passed++;
        cyc(2'b00, 13'd0, 1'b1);
        total++; if ({rd_valid, rd_data} !== {1'b1, 13'd8191}) $display("FAIL range_pop1 got %h exp %h", {rd_valid, rd_data}, {1'b1, 13'd8191});
        else passed++;
        cyc(2'b00, 13'd0, 1'b0);
    endtask

    task automatic test_zero;
        cyc(2'b10, 13'd0, 1'b0);
        cyc(2'b11, 13'd0, 1'b0);
        total++; if (st !== {1'b1, 7'd0, 1'b1, 1'b0, 1'b0}) $display("FAIL zero_done got %h exp %h", st, {1'b1, 7'd0, 1'b1, 1'b0, 1'b0});
        else passed++;
        cyc(2'b11, 13'd0, 1'b1);
        total++; if ({vec_ready, rd_valid} !== 2'b00) $display("FAIL zero_idle got %b exp 00", {vec_ready, rd_valid});
        else passed++;
        cyc(2'b00, 13'd0, 1'b0);
        cyc(2'b11, 13'd0, 1'b0);
        total++; if (vec_ready !== 1'b0) $display("FAIL zero_done_in_idle got %b exp 0", vec_ready);
        else passed++;
    endtask

    task automatic test_back_to_back;
        cyc(2'b10, 13'd0, 1'b0);
        cyc(2'b01, 13'd4900, 1'b0);
        cyc(2'b01, 13'd7, 1'b0);
        cyc(2'b11, 13'd0, 1'b0);
        cyc(2'b11, 13'd0, 1'b1);
        total++; if ({rd_valid, rd_data} !== {1'b1, 13'd4900}) $display("FAIL abandon_pop got %h exp %h", {rd_valid, rd_data}, {1'b1, 13'd4900});
        else passed++;
        cyc(2'b10, 13'd0, 1'b1);
        total++; if ({vec_ready, rd_valid, err_range, err_ovf, rd_empty} !== 5'b00001)
            $display("FAIL abandon got %b exp 00001", {vec_ready, rd_valid, err_range, err_ovf, rd_empty});
        else passed++;
        cyc(2'b01, 13'd5000, 1'b0);
        cyc(2'b01, 13'd11, 1'b0);
        cyc(2'b11, 13'd0, 1'b0);
        total++; if (st !== {1'b1, 7'd2, 1'b0, 1'b1, 1'b0}) $display("FAIL pre_rst got %h exp %h", st, {1'b1, 7'd2, 1'b0, 1'b1, 1'b0});
        else passed++;
        cyc(2'b11, 13'd0, 1'b1);
        cyc(2'b10, 13'd0, 1'b0);
        cyc(2'b01, 13'd4901, 1'b0);
        rst_b = 1'b0;
        #1;
        total++; if ({st, rd_valid, rd_data} !== {1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0})
            $display("FAIL async_rst got %h exp %h", {st, rd_valid, rd_data}, {1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 13'd0});
        else passed++;
        #3;
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(2'b11, 13'd0, 1'b1);
            total++; if ({vec_ready, rd_valid} !== 2'b00) $display("FAIL post_rst cyc %0d got %b exp 00", i, {vec_ready, rd_valid});
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_retry;
        test_ovf;
        test_range;
        test_zero;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/err_collect.md
# err_collect

Receiving end of the error-vector index stream emitted by the syndrome/error-vector generator. It samples the two-bit `err_valid` code and the 13-bit `err_idx` bus every cycle and buffers the indices of the current candidate vector. It discards the buffer whenever the generator restarts a candidate, and on completion freezes the set and exposes it through a pop-style read port to the downstream signature assembler.

## Interface
Parameters:
- `IDX_W`, 13: index width; matches `err_idx`.
- `DEPTH`, 64: maximum buffered indices (maximum vector weight).
- `N_MAX`, 4900: code length; a valid index satisfies idx < N_MAX.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: reset, asynchronous, active-low.
- `err_valid` in 2: stream code. 00 = idle/hold, 01 = index valid, 10 = clear current vector, 11 = all vectors found.
- `err_idx` in IDX_W: index; qualified only by `err_valid` = 01.
- `rd_en` in 1: pop one buffered index.
- `vec_ready` out 1: a completed vector is held for readout.
- `weight` out 7: number of indices in the held vector, saturating at DEPTH.
- `rd_data` out IDX_W: popped index, registered.
- `rd_valid` out 1: `rd_data` valid; one-cycle pulse.
- `rd_empty` out 1: every held index has been popped. High whenever `vec_ready` = 0.
- `err_range` out 1: sticky; an index ≥ N_MAX was received in the current vector.
- `err_ovf` out 1: sticky; more than DEPTH indices were received in the current vector.

## Operation
- Storage:
  - DEPTH × IDX_W register array.
  - `wr_cnt`: 7 bits.
  - `rd_ptr`: 7 bits.
  - `prev_code`: 2 bits, the `err_valid` value from the previous cycle. Used for edge detection.
- The done event is `err_valid` = 11 while `prev_code` ≠ 11. A steady 11 is not an event, because the generator holds 11 while idle.
- State machine:
  - IDLE: all inputs are ignored except 10, which clears `wr_cnt`, `err_range` and `err_ovf`, then goes to COLLECT.
  - COLLECT, input 01: writes `err_idx` at `mem[wr_cnt]` and increments `wr_cnt`.
    - If `wr_cnt` = DEPTH, the index is dropped, `err_ovf` is set and `wr_cnt` holds.
    - If idx ≥ N_MAX, the index is still stored and `err_range` is set.
  - COLLECT, input 10: restarts the candidate. Clears `wr_cnt` and both sticky flags, and stays in COLLECT.
  - COLLECT, input 00 or a steady 11: hold.
  - COLLECT, done event: `weight` is set to `wr_cnt`, `rd_ptr` is cleared, and the state goes to READY.
  - READY: `vec_ready` = 1.
    - `rd_en` with `rd_ptr` < `weight` pops: `rd_data` = `mem[rd_ptr]`, `rd_valid` = 1 next cycle, `rd_ptr`++.
    - `rd_en` while `rd_empty` is ignored: no `rd_valid`, no pointer change.
    - When `rd_ptr` = `weight`, `rd_empty` = 1. The next cycle returns to IDLE and `vec_ready` falls.
    - Input 10 in READY abandons the unread set: go to COLLECT with a cleared buffer and `vec_ready` = 0. Any `rd_en` in that same cycle is ignored.
    - Input 01 in READY is ignored and does not corrupt the held set.
- Width rules:
  - `wr_cnt`, `rd_ptr` and `weight` never exceed DEPTH.
  - `err_idx` is compared against N_MAX as an unsigned IDX_W-bit value.

## Timing
- Reset: state = IDLE and `prev_code` = 11, so holding 11 out of reset is not a done event. All outputs are 0 except `rd_empty` = 1. The buffer contents are don't-care.
- Reset mid-collection or mid-readout: the set is lost immediately, the outputs take their reset values asynchronously, and no `rd_valid` occurs afterwards.
- Input latency:
  - An index sampled at edge k is stored by edge k and is readable in READY.
  - Done sampled at edge k gives `vec_ready` = 1 and a valid `weight` after edge k.
- Read latency: `rd_en` high at edge k gives `rd_data`/`rd_valid` after edge k. `rd_valid` stays high for one cycle per pop. Back-to-back pops run one index per cycle.
- Drain: after the final pop at edge k, `rd_empty` = 1 after edge k and `vec_ready` = 0 after edge k+1.
- Zero weight: done with no indices gives `vec_ready` = 1 and `rd_empty` = 1 for exactly one cycle, then IDLE.
- Throughput: at most one index per cycle.

## Test plan
- Reset with `err_valid` held at 11 for 10 cycles -> `vec_ready` stays 0 and all outputs keep their reset values.
- Sequence 10, 01(17), 01(4899-1=4898), 00, 01(3), 11 -> `vec_ready` = 1, `weight` = 3, no flags set. Three pops return 17, 4898, 3 on consecutive cycles, then `rd_empty` = 1 and `vec_ready` falls one cycle later.
- Sequence 10, 01(5), 01(6), 10, 01(9), 11 -> `weight` = 1 and a single pop returns 9 (the retry discarded 5 and 6).
- Sequence 10, then 66 indices 0..65, then 11 -> `weight` = 64, `err_ovf` = 1, and the last pop returns 63.
- Sequence 10, 01(4900), 01(8191), 11 -> `weight` = 2, `err_range` = 1, pops return 4900 and 8191.
- Collect 2 indices, pop 1, then drive 10 together with `rd_en` -> no `rd_valid`, `vec_ready` = 0 and `err_range`/`err_ovf` cleared. Next, deassert `rst_b` mid-collection -> immediate reset values.
